// File: rtl/adder_exec_unit_if.sv
// rtl/adder_exec_unit_if.sv - issue handshake and CDB/branch broadcast bundle
// The unit uses the slave side; the reservation station / CDB fabric uses master.
interface adder_exec_unit_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] in_incr_pc;
  logic [DATA_W-1:0] in_offset;
  logic [TAG_W-1:0]  in_tag;
  logic [ROB_W-1:0]  in_rob;

  logic              cdb_req;
  logic              cdb_grant;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [ROB_W-1:0]  cdb_rob;
  logic              br_valid;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_incr_pc, in_offset, in_tag, in_rob,
    output cdb_grant,
    input  in_ready,
    input  cdb_req, cdb_tag, cdb_data, cdb_rob, br_valid, br_taken, br_target
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_incr_pc, in_offset, in_tag, in_rob,
    input  cdb_grant,
    output in_ready,
    output cdb_req, cdb_tag, cdb_data, cdb_rob, br_valid, br_taken, br_target
  );
endinterface

// File: rtl/adder_exec_unit.sv
// rtl/adder_exec_unit.sv - two-stage add/sub/beq/jmp unit with CDB writeback
// E1 captures the issued op; W holds the computed result until the CDB grants it.
module adder_exec_unit #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  adder_exec_unit_if.slave  bus
);
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_BEQ = 6'b111001;
  localparam logic [5:0] OP_JMP = 6'b011010;

  logic              e1_valid_q;
  logic [5:0]        e1_op_q;
  logic [DATA_W-1:0] e1_a_q, e1_b_q, e1_pc_q, e1_off_q;
  logic [TAG_W-1:0]  e1_tag_q;
  logic [ROB_W-1:0]  e1_rob_q;

  logic              w_valid_q;
  logic [DATA_W-1:0] w_data_q, w_target_q;
  logic [TAG_W-1:0]  w_tag_q;
  logic [ROB_W-1:0]  w_rob_q;
  logic              w_br_valid_q, w_br_taken_q;

  logic [DATA_W-1:0] w_data_d, w_target_d, target;
  logic              w_br_valid_d, w_br_taken_d;

  logic w_free, advance, accept;

  // A grant with W empty is harmless here: W is already free.
  assign w_free      = !w_valid_q || bus.cdb_grant;
  assign advance     = e1_valid_q && w_free;
  assign bus.in_ready = !flush && (!e1_valid_q || w_free);
  assign accept      = bus.in_valid && bus.in_ready;

  assign target = e1_pc_q + (e1_off_q << 2);

  always_comb begin
    w_data_d     = '0;
    w_target_d   = '0;
    w_br_valid_d = 1'b0;
    w_br_taken_d = 1'b0;
    case (e1_op_q)
      OP_ADD: w_data_d = e1_a_q + e1_b_q;
      OP_SUB: w_data_d = e1_a_q - e1_b_q;
      OP_BEQ: begin
        w_br_valid_d = 1'b1;
        w_br_taken_d = (e1_a_q == e1_b_q);
        w_data_d     = w_br_taken_d ? target : e1_pc_q;
        w_target_d   = w_br_taken_d ? target : '0;
      end
      OP_JMP: begin
        w_br_valid_d = 1'b1;
        w_br_taken_d = 1'b1;
        w_data_d     = target;
        w_target_d   = target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_valid_q   <= 1'b0;
      e1_op_q      <= '0;
      e1_a_q       <= '0;
      e1_b_q       <= '0;
      e1_pc_q      <= '0;
      e1_off_q     <= '0;
      e1_tag_q     <= '0;
      e1_rob_q     <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      w_target_q   <= '0;
      w_tag_q      <= '0;
      w_rob_q      <= '0;
      w_br_valid_q <= 1'b0;
      w_br_taken_q <= 1'b0;
    end else if (flush) begin
      e1_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
    end else begin
      if (advance) begin
        w_valid_q    <= 1'b1;
        w_data_q     <= w_data_d;
        w_target_q   <= w_target_d;
        w_tag_q      <= e1_tag_q;
        w_rob_q      <= e1_rob_q;
        w_br_valid_q <= w_br_valid_d;
        w_br_taken_q <= w_br_taken_d;
      end else if (w_valid_q && bus.cdb_grant) begin
        w_valid_q <= 1'b0;
      end

      if (accept) begin
        e1_valid_q <= 1'b1;
        e1_op_q    <= bus.in_opcode;
        e1_a_q     <= bus.in_a;
        e1_b_q     <= bus.in_b;
        e1_pc_q    <= bus.in_incr_pc;
        e1_off_q   <= bus.in_offset;
        e1_tag_q   <= bus.in_tag;
        e1_rob_q   <= bus.in_rob;
      end else if (advance) begin
        e1_valid_q <= 1'b0;
      end
    end
  end

  // Stale W contents never leak onto the bus once the slot is empty.
  assign bus.cdb_req   = w_valid_q;
  assign bus.cdb_data  = w_valid_q ? w_data_q : '0;
  assign bus.cdb_tag   = w_valid_q ? w_tag_q : '0;
  assign bus.cdb_rob   = w_valid_q ? w_rob_q : '0;
  assign bus.br_valid  = w_valid_q && w_br_valid_q;
  assign bus.br_taken  = w_valid_q && w_br_taken_q;
  assign bus.br_target = (w_valid_q && w_br_valid_q) ? w_target_q : '0;
endmodule

// File: tb/tb_adder_exec_unit.sv
// tb/tb_adder_exec_unit.sv - directed self-checking bench for adder_exec_unit
module tb_adder_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_BEQ = 6'b111001;
  localparam logic [5:0] OP_JMP = 6'b011010;

  adder_exec_unit_if #(.DATA_W(64), .TAG_W(4), .ROB_W(2)) bus ();

  adder_exec_unit #(.DATA_W(64), .TAG_W(4), .ROB_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] off,
                       input logic [3:0] tag, input logic [1:0] rob);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_incr_pc = pc;
    bus.in_offset  = off;
    bus.in_tag     = tag;
    bus.in_rob     = rob;
  endtask

  // Accept one op, then advance to the cycle where its result is in W.
  task automatic issue(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] off,
                       input logic [3:0] tag, input logic [1:0] rob);
    drive(op, a, b, pc, off, tag, rob);
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_incr_pc = '0;
    bus.in_offset = '0;
    bus.in_tag = '0;
    bus.in_rob = '0;
    bus.cdb_grant = 1'b1;

    #1;
    chk("rst_cdb_req", bus.cdb_req, 1'b0);
    chk("rst_cdb_data", bus.cdb_data, 64'd0);
    chk("rst_br_valid", bus.br_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;

    // add: result visible two edges after accept, not after one
    drive(OP_ADD, 64'd5, 64'd7, 64'd0, 64'd0, 4'd1, 2'd2);
    step();
    bus.in_valid = 1'b0;
    chk("add_lat_req", bus.cdb_req, 1'b0);
    step();
    chk("add_req", bus.cdb_req, 1'b1);
    chk("add_data", bus.cdb_data, 64'd12);
    chk("add_tag", bus.cdb_tag, 4'd1);
    chk("add_rob", bus.cdb_rob, 2'd2);
    chk("add_br_valid", bus.br_valid, 1'b0);
    step();
    chk("add_retired", bus.cdb_req, 1'b0);

    issue(OP_SUB, 64'd3, 64'd5, 64'd0, 64'd0, 4'd2, 2'd1);
    chk("sub_data", bus.cdb_data, 64'hFFFF_FFFF_FFFF_FFFE);
    step();

    issue(6'b000001, 64'd3, 64'd5, 64'd0, 64'd0, 4'd3, 2'd0);
    chk("unk_req", bus.cdb_req, 1'b1);
    chk("unk_data", bus.cdb_data, 64'd0);
    chk("unk_br_valid", bus.br_valid, 1'b0);
    step();

    issue(OP_BEQ, 64'd9, 64'd9, 64'h100, 64'd4, 4'd4, 2'd3);
    chk("beq_t_valid", bus.br_valid, 1'b1);
    chk("beq_t_taken", bus.br_taken, 1'b1);
    chk("beq_t_target", bus.br_target, 64'h110);
    chk("beq_t_data", bus.cdb_data, 64'h110);
    step();

    issue(OP_BEQ, 64'd9, 64'd8, 64'h100, 64'd4, 4'd4, 2'd3);
    chk("beq_n_valid", bus.br_valid, 1'b1);
    chk("beq_n_taken", bus.br_taken, 1'b0);
    chk("beq_n_target", bus.br_target, 64'd0);
    chk("beq_n_data", bus.cdb_data, 64'h100);
    step();

    issue(OP_JMP, 64'd0, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 2'd1);
    chk("jmp_taken", bus.br_taken, 1'b1);
    chk("jmp_target", bus.br_target, 64'hFC);
    chk("jmp_data", bus.cdb_data, 64'hFC);
    step();
    chk("idle_after_ops", bus.cdb_req, 1'b0);

    // Stall: three back-to-back ops with no grant
    bus.cdb_grant = 1'b0;
    drive(OP_ADD, 64'd1, 64'd1, 64'd0, 64'd0, 4'd3, 2'd0);
    step();
    drive(OP_ADD, 64'd2, 64'd2, 64'd0, 64'd0, 4'd4, 2'd1);
    chk("stall_ready_b", bus.in_ready, 1'b1);
    step();
    drive(OP_ADD, 64'd3, 64'd3, 64'd0, 64'd0, 4'd5, 2'd2);
    chk("stall_ready_c", bus.in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ready", bus.in_ready, 1'b0);
      chk("stall_req", bus.cdb_req, 1'b1);
      chk("stall_data", bus.cdb_data, 64'd2);
      chk("stall_tag", bus.cdb_tag, 4'd3);
    end
    bus.cdb_grant = 1'b1;
    #1;
    chk("grant_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("order_b_data", bus.cdb_data, 64'd4);
    chk("order_b_tag", bus.cdb_tag, 4'd4);
    step();
    chk("order_c_data", bus.cdb_data, 64'd6);
    chk("order_c_tag", bus.cdb_tag, 4'd5);
    step();
    chk("order_drained", bus.cdb_req, 1'b0);

    // Flush with both stages full and a grant in the same cycle
    bus.cdb_grant = 1'b0;
    drive(OP_ADD, 64'd10, 64'd1, 64'd0, 64'd0, 4'd6, 2'd0);
    step();
    drive(OP_ADD, 64'd20, 64'd1, 64'd0, 64'd0, 4'd7, 2'd1);
    step();
    bus.in_valid = 1'b0;
    chk("full_before_flush", bus.in_ready, 1'b0);
    flush = 1'b1;
    bus.cdb_grant = 1'b1;
    #1;
    chk("flush_ready", bus.in_ready, 1'b0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_req", bus.cdb_req, 1'b0);
    chk("flush_data", bus.cdb_data, 64'd0);
    chk("post_flush_ready", bus.in_ready, 1'b1);
    step();
    chk("flush_no_late", bus.cdb_req, 1'b0);

    // Asynchronous reset mid-cycle while broadcasting
    bus.cdb_grant = 1'b0;
    drive(OP_JMP, 64'd0, 64'd0, 64'h200, 64'd1, 4'd8, 2'd3);
    step();
    drive(OP_ADD, 64'd4, 64'd4, 64'd0, 64'd0, 4'd9, 2'd2);
    step();
    bus.in_valid = 1'b0;
    chk("prerst_req", bus.cdb_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", bus.cdb_req, 1'b0);
    chk("arst_data", bus.cdb_data, 64'd0);
    chk("arst_tag", bus.cdb_tag, 4'd0);
    chk("arst_br_target", bus.br_target, 64'd0);
    chk("arst_br_valid", bus.br_valid, 1'b0);
    step();
    rst_n = 1'b1;
    bus.cdb_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_req", bus.cdb_req, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
